// File: rtl/dff_pipe_if.sv
// ============================================================================
// Module  : dff_pipe_if
// Brief   : Control/data bundle between a pipeline driver and dff_pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAP_W = 1
);
    logic             en;
    logic             clr;
    logic             d_valid;
    logic [WIDTH-1:0] d;
    logic [TAP_W-1:0] tap_sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [WIDTH-1:0] tap;
    logic             changed;

    modport master (
        output en, clr, d_valid, d, tap_sel,
        input  q, q_valid, tap, changed
    );

    modport slave (
        input  en, clr, d_valid, d, tap_sel,
        output q, q_valid, tap, changed
    );
endinterface

`default_nettype wire

// File: rtl/dff_pipe.sv
// ============================================================================
// Module  : dff_pipe
// Brief   : DEPTH-stage enabled/clearable register pipeline with valid, tap, change flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire         clk,
    input  wire         rst,
    dff_pipe_if.slave   bus
);
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic             r_changed;
    logic [WIDTH-1:0] w_next_last;
    logic [WIDTH-1:0] w_tap;

    // Value the last stage will take on an enabled shift.
    generate
        if (DEPTH == 1) begin : g_single
            assign w_next_last = bus.d;
        end else begin : g_chain
            assign w_next_last = r_stage[DEPTH-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
            r_valid   <= '0;
            r_changed <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
            r_valid   <= '0;
            r_changed <= 1'b0;
        end else if (bus.en) begin
            r_stage[0] <= bus.d;
            r_valid[0] <= bus.d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            r_changed <= (w_next_last != r_stage[DEPTH-1]);
        end else begin
            r_changed <= 1'b0;
        end
    end

    // Out-of-range selects fall through to the last stage.
    always_comb begin
        w_tap = r_stage[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(bus.tap_sel) == i) begin
                w_tap = r_stage[i];
            end
        end
    end

    assign bus.q       = r_stage[DEPTH-1];
    assign bus.q_valid = r_valid[DEPTH-1];
    assign bus.tap     = w_tap;
    assign bus.changed = r_changed;

    logic w_unused_tap_w;
    assign w_unused_tap_w = (TAP_W == $bits(bus.tap_sel));

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe.sv
// ============================================================================
// Module  : tb_dff_pipe
// Brief   : Directed self-checking bench for dff_pipe (DEPTH=3 and DEPTH=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_pipe;
    logic clk;
    logic rst3;
    logic rst1;
    int   n_vec;
    int   n_err;

    dff_pipe_if #(.WIDTH(8), .TAP_W(2)) if3 ();
    dff_pipe_if #(.WIDTH(1), .TAP_W(1)) if1 ();

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (if3)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] q, input logic qv, input logic ch);
        chk({tag, ".q"},       32'(if3.q),       32'(q));
        chk({tag, ".q_valid"}, 32'(if3.q_valid), 32'(qv));
        chk({tag, ".changed"}, 32'(if3.changed), 32'(ch));
    endtask

    task automatic cyc3(input logic e, input logic c, input logic dv, input logic [7:0] dd);
        if3.en      = e;
        if3.clr     = c;
        if3.d_valid = dv;
        if3.d       = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input logic dv, input logic dd);
        if1.en      = 1'b1;
        if1.clr     = 1'b0;
        if1.d_valid = dv;
        if1.d       = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst3 = 1'b1;
        rst1 = 1'b1;
        if3.en = 1'b0; if3.clr = 1'b0; if3.d_valid = 1'b0; if3.d = 8'h00; if3.tap_sel = 2'd0;
        if1.en = 1'b0; if1.clr = 1'b0; if1.d_valid = 1'b0; if1.d = 1'b0; if1.tap_sel = 1'b0;
        #2;
        rst3 = 1'b0;
        rst1 = 1'b0;
        #1;
        chk3("reset", 8'h5A, 1'b0, 1'b0);
        chk("reset.tap", 32'(if3.tap), 32'h5A);
        chk("d1_reset.q", 32'(if1.q), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b1;

        // Streaming: first data reaches q after the third edge
        cyc3(1, 0, 1, 8'h01); chk3("s1", 8'h5A, 1'b0, 1'b0);
        cyc3(1, 0, 1, 8'h02); chk3("s2", 8'h5A, 1'b0, 1'b0);
        cyc3(1, 0, 1, 8'h03); chk3("s3", 8'h01, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'h04); chk3("s4", 8'h02, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'hA1); chk3("s5", 8'h03, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'hA2); chk3("s6", 8'h04, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'hA3); chk3("s7", 8'hA1, 1'b1, 1'b1);

        // Stall: pipe holds [A3,A2,A1]
        if3.tap_sel = 2'd0; cyc3(0, 0, 0, 8'hFF);
        chk3("stall0", 8'hA1, 1'b1, 1'b0); chk("stall0.tap", 32'(if3.tap), 32'hA3);
        if3.tap_sel = 2'd1; cyc3(0, 0, 0, 8'hFF);
        chk3("stall1", 8'hA1, 1'b1, 1'b0); chk("stall1.tap", 32'(if3.tap), 32'hA2);
        if3.tap_sel = 2'd2; cyc3(0, 0, 0, 8'hFF);
        chk3("stall2", 8'hA1, 1'b1, 1'b0); chk("stall2.tap", 32'(if3.tap), 32'hA1);
        if3.tap_sel = 2'd0; cyc3(0, 0, 0, 8'hFF);
        chk3("stall3", 8'hA1, 1'b1, 1'b0); chk("stall3.tap", 32'(if3.tap), 32'hA3);
        cyc3(1, 0, 1, 8'hB0); chk3("resume0", 8'hA2, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'hB1); chk3("resume1", 8'hA3, 1'b1, 1'b1);

        // Clear beats enable; FF must not be captured
        cyc3(1, 1, 1, 8'hFF); chk3("clr", 8'h5A, 1'b0, 1'b0);
        if3.tap_sel = 2'd0; #1; chk("clr.tap0", 32'(if3.tap), 32'h5A);
        if3.tap_sel = 2'd1; #1; chk("clr.tap1", 32'(if3.tap), 32'h5A);

        // Load [33,22,11] then sweep tap_sel
        cyc3(1, 0, 1, 8'h11);
        cyc3(1, 0, 1, 8'h22);
        cyc3(1, 0, 1, 8'h33); chk3("load", 8'h11, 1'b1, 1'b1);
        cyc3(0, 0, 0, 8'h00);
        if3.tap_sel = 2'd0; #1; chk("tap0", 32'(if3.tap), 32'h33);
        if3.tap_sel = 2'd1; #1; chk("tap1", 32'(if3.tap), 32'h22);
        if3.tap_sel = 2'd2; #1; chk("tap2", 32'(if3.tap), 32'h11);
        if3.tap_sel = 2'd3; #1; chk("tap3", 32'(if3.tap), 32'h11);

        // Repeated 11s: changed drops once q stops moving
        cyc3(1, 0, 1, 8'h11); chk3("eq1", 8'h22, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'h11); chk3("eq2", 8'h33, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'h11); chk3("eq3", 8'h11, 1'b1, 1'b1);
        cyc3(1, 0, 1, 8'h11); chk3("eq4", 8'h11, 1'b1, 1'b0);
        cyc3(1, 0, 1, 8'h11); chk3("eq5", 8'h11, 1'b1, 1'b0);

        // Async reset mid-cycle with a full pipe
        cyc3(1, 0, 1, 8'hC1); chk3("c1", 8'h11, 1'b1, 1'b0);
        cyc3(1, 0, 1, 8'hC2); chk3("c2", 8'h11, 1'b1, 1'b0);
        cyc3(1, 0, 1, 8'hC3); chk3("c3", 8'hC1, 1'b1, 1'b1);
        #3;
        rst3 = 1'b0;
        #1;
        chk3("arst", 8'h5A, 1'b0, 1'b0);
        if3.tap_sel = 2'd0; #1; chk("arst.tap", 32'(if3.tap), 32'h5A);
        if3.en = 1'b1; if3.d = 8'hEE; if3.d_valid = 1'b1;
        @(posedge clk); #1;
        chk3("arst_hold", 8'h5A, 1'b0, 1'b0);
        rst3 = 1'b1;
        cyc3(1, 0, 1, 8'hD1); chk3("post_rst", 8'h5A, 1'b0, 1'b0);
        chk("post_rst.tap0", 32'(if3.tap), 32'hD1);

        // DEPTH=1: plain enabled flip-flop, tap mirrors q
        rst1 = 1'b1;
        cyc1(1'b1, 1'b0);
        chk("d1_a.q", 32'(if1.q), 32'h0); chk("d1_a.changed", 32'(if1.changed), 32'h1);
        chk("d1_a.q_valid", 32'(if1.q_valid), 32'h1);
        cyc1(1'b0, 1'b1);
        chk("d1_b.q", 32'(if1.q), 32'h1); chk("d1_b.changed", 32'(if1.changed), 32'h1);
        chk("d1_b.q_valid", 32'(if1.q_valid), 32'h0);
        if1.tap_sel = 1'b1; #1; chk("d1_b.tap", 32'(if1.tap), 32'h1);
        cyc1(1'b1, 1'b1);
        chk("d1_c.q", 32'(if1.q), 32'h1); chk("d1_c.changed", 32'(if1.changed), 32'h0);
        cyc1(1'b1, 1'b0);
        chk("d1_d.q", 32'(if1.q), 32'h0); chk("d1_d.tap", 32'(if1.tap), 32'h0);
        #3;
        rst1 = 1'b0;
        #1;
        chk("d1_arst.q", 32'(if1.q), 32'h1);
        chk("d1_arst.q_valid", 32'(if1.q_valid), 32'h0);
        chk("d1_arst.changed", 32'(if1.changed), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/dff_pipe.md
# dff_pipe

Parameterized D flip-flop pipeline: a chain of DEPTH registers of WIDTH bits with clock enable, synchronous clear, valid tracking, a selectable stage tap and a change flag on the output stage. It is the base storage element behind the `dff` block and its `dff_if` interface, and is used wherever a registered, resettable delay of 1..N cycles is needed. With DEPTH=1 it behaves as a plain enabled, resettable D flip-flop.

## Interface

- WIDTH, 8, data width in bits (>=1)
- DEPTH, 1, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every data stage on reset or clear (WIDTH bits)
- TAP_W, max(1,$clog2(DEPTH)), width of tap_sel (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  clock enable; pipeline advances only when 1
- clr  in  1  synchronous clear; overrides en
- d_valid  in  1  qualifier accompanying d
- d  in  WIDTH  data input to stage 0
- tap_sel  in  TAP_W  selects which stage drives tap
- q  out  WIDTH  last stage data (stage DEPTH-1)
- q_valid  out  1  valid bit of last stage
- tap  out  WIDTH  data of stage tap_sel (combinational mux of registers)
- changed  out  1  registered flag: last stage took a new, different value on the previous edge

## Operation

- State: data stage[0..DEPTH-1] (WIDTH bits each), valid bit v[0..DEPTH-1], changed register.
- Priority per edge: rst low > clr > en > hold.
- rst low (async, any time): all stages = RESET_VAL, all v = 0, changed = 0; outputs reflect this immediately, without a clock edge.
- clr=1 at edge (rst high): all stages = RESET_VAL, all v = 0, changed = 0, regardless of en.
- en=1, clr=0: stage[0] <= d, v[0] <= d_valid; stage[i] <= stage[i-1], v[i] <= v[i-1] for i>=1. d is captured whether or not d_valid is set.
- en=0, clr=0: all stages and v hold; changed <= 0.
- changed <= 1 only on an enabled shift where the new stage[DEPTH-1] differs from its old value; else 0. Pulse lasts one cycle per qualifying edge.
- q = stage[DEPTH-1], q_valid = v[DEPTH-1].
- tap = stage[tap_sel]; tap_sel >= DEPTH selects stage[DEPTH-1] (= q). For DEPTH=1 tap_sel is ignored and tap = q.
- No X propagation from unused bits; all registers reset.

## Timing

- Latency d -> q: DEPTH enabled rising edges; with en held high, d sampled at edge k appears on q after edge k+DEPTH-1 (DEPTH=1: visible right after the capturing edge).
- Cycles with en=0 stretch latency one-for-one; no data is lost or duplicated.
- Reset assertion is asynchronous; deassertion is synchronized externally to clk. The first capture happens on the first rising edge with rst high.
- Reset mid-operation discards all in-flight data; after release q = RESET_VAL and q_valid = 0 until new data traverses the pipe.
- clr and en high together: clear wins; d on that edge is discarded.
- tap is combinational from tap_sel and registers; changed, q, q_valid are pure register outputs (no combinational path from inputs).

## Test plan

- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'h5A; drive rst low mid-cycle with pipe full -> q=8'h5A, q_valid=0, changed=0 immediately, before any clk edge.
- Streaming: DEPTH=3, en=1, d=8'h01,02,03,04 with d_valid=1 on successive edges -> q=8'h01 with q_valid=1 after the 3rd edge, then 02,03,04 on following edges; changed=1 on each of those cycles.
- Enable stall: DEPTH=3, load 8'hA1,A2,A3, hold en=0 for 4 cycles -> q and tap values frozen, changed=0; resume en=1 -> sequence continues with no loss.
- Clear priority: DEPTH=3 full of valid data, assert clr=1 and en=1 with d=8'hFF for one edge -> all stages RESET_VAL, q_valid=0, 8'hFF not captured.
- Tap and changed: DEPTH=3 holding stage0=8'h33, stage1=8'h22, stage2=8'h11; tap_sel=0,1,2,3 -> tap=33,22,11,11. Shift in equal values 8'h11 repeatedly -> changed stays 0 once q is constant.
- DEPTH=1 flip-flop mode: d=1/0 toggling with en=1 -> q follows d one edge later; rst low forces q=RESET_VAL asynchronously.
